// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp codes, FSM state
// encoding and op-class helpers. Optional macro: MDU_MADD_EN (enables the
// madd/maddu/msub/msubu accumulate ops).
package mdu_pkg;

    localparam logic [3:0] MD_NOP   = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_t;

    // True for codes that launch a multi-cycle op when Start is seen.
    function automatic logic md_is_launch(input logic [3:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MDU_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return r;
    endfunction

    // True for the divide codes (longer latency, divide-by-zero suppression).
    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the multiply/divide unit: produces the 64-bit
// {hi,lo} result for the selected op. Optional macro: MDU_MADD_EN adds the
// accumulate ops, which need the current HI/LO values.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  i_op,
`ifdef MDU_MADD_EN
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
`endif
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_res
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic        w_sdiv;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_dvsr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    // Low 64 bits of a product of sign-extended operands is the signed product.
    assign w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide is done on magnitudes, then signs are restored: quotient
    // negative when operand signs differ, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign w_sdiv  = (i_op == MD_DIV);
    assign w_neg_a = w_sdiv & i_a[31];
    assign w_neg_b = w_sdiv & i_b[31];
    assign w_mag_a = w_neg_a ? (32'd0 - i_a) : i_a;
    assign w_mag_b = w_neg_b ? (32'd0 - i_b) : i_b;
    // A zero divisor is replaced so the divider never sees it; the top level
    // suppresses the write-back in that case anyway.
    assign w_dvsr  = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_uq    = w_mag_a / w_dvsr;
    assign w_ur    = w_mag_a % w_dvsr;
    assign w_q     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign w_r     = w_neg_a ? (32'd0 - w_ur) : w_ur;

    // Select the result for the requested op.
    always_comb begin
        o_res = 64'd0;
        case (i_op)
            MD_MULT:  o_res = w_sprod;
            MD_MULTU: o_res = w_uprod;
            MD_DIV,
            MD_DIVU:  o_res = {w_r, w_q};
`ifdef MDU_MADD_EN
            MD_MADD:  o_res = {i_hi, i_lo} + w_sprod;
            MD_MADDU: o_res = {i_hi, i_lo} + w_uprod;
            MD_MSUB:  o_res = {i_hi, i_lo} - w_sprod;
            MD_MSUBU: o_res = {i_hi, i_lo} - w_uprod;
`endif
            default:  o_res = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models fixed op latency and
// drives Busy for the hazard unit. Optional macro: MDU_MADD_EN.
//
// Handshake: Start is a one-cycle launch pulse sampled on the rising edge
// while idle; Busy is high from the cycle after launch until the cycle the
// new HI/LO appear. Start while Busy is ignored (the hazard unit prevents it).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_t       r_state;
    mdu_state_t       w_next;
    logic             w_launch;
    logic             w_last;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_res;
    logic             r_wr;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [63:0]      w_res;

    mdu_arith u_arith (
        .i_op  (MDOp),
`ifdef MDU_MADD_EN
        .i_hi  (r_hi),
        .i_lo  (r_lo),
`endif
        .i_a   (A),
        .i_b   (B),
        .o_res (w_res)
    );

    assign w_last = (r_state == MDU_RUN) && (r_cnt == CNT_W'(1));

    // Next-state logic: launch from idle, return once the count expires.
    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        case (r_state)
            MDU_IDLE: begin
                if (Start && md_is_launch(MDOp)) begin
                    w_launch = 1'b1;
                    w_next   = MDU_RUN;
                end
            end
            MDU_RUN: begin
                if (w_last) begin
                    w_next = MDU_IDLE;
                end
            end
            default: w_next = MDU_IDLE;
        endcase
    end

    // State register and registered Busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MDU_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == MDU_RUN);
        end
    end

    // Latency counter and captured result; divide-by-zero clears the write flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_res <= 64'd0;
            r_wr  <= 1'b0;
        end else if (w_launch) begin
            r_cnt <= md_is_div(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            r_res <= w_res;
            r_wr  <= !(md_is_div(MDOp) && (B == 32'd0));
        end else if (r_state == MDU_RUN) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Architectural HI/LO: result commit at end of RUN, mthi/mtlo only when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_last) begin
            if (r_wr) begin
                r_hi <= r_res[63:32];
                r_lo <= r_res[31:0];
            end
        end else if (r_state == MDU_IDLE) begin
            if (MDOp == MD_MTHI) begin
                r_hi <= A;
            end else if (MDOp == MD_MTLO) begin
                r_lo <= A;
            end
        end
    end

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a cycle-stamped reference model plus
// directed vectors with hand-computed results.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  MDOp = MD_NOP;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_pend = 64'd0;
  bit          m_pend_wr = 1'b0;
  bit          m_run = 1'b0;
  longint      cyc = 0;
  longint      m_done_at = 0;

  // Result of an op from the arithmetic definition; lat=0 means no launch.
  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi, input logic [31:0] lo,
                                   output logic [63:0] r, output bit wr, output int lat);
    longint sa, sb, sq, sr;
    logic [63:0] smul, umul, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    smul = sa * sb;
    umul = {32'h0, a} * {32'h0, b};
    r = {hi, lo};
    wr = 1'b1;
    lat = 0;
    case (op)
      MD_MULT:  begin r = smul; lat = MC; end
      MD_MULTU: begin r = umul; lat = MC; end
      MD_DIV: begin
        lat = DC;
        if (b == 32'd0) wr = 1'b0;
        else begin sq = sa / sb; sr = sa % sb; r = {sr[31:0], sq[31:0]}; end
      end
      MD_DIVU: begin
        lat = DC;
        if (b == 32'd0) wr = 1'b0;
        else begin uq = {32'h0, a} / {32'h0, b}; ur = {32'h0, a} % {32'h0, b}; r = {ur[31:0], uq[31:0]}; end
      end
`ifdef MDU_MADD_EN
      MD_MADD:  begin r = {hi, lo} + smul; lat = MC; end
      MD_MADDU: begin r = {hi, lo} + umul; lat = MC; end
      MD_MSUB:  begin r = {hi, lo} - smul; lat = MC; end
      MD_MSUBU: begin r = {hi, lo} - umul; lat = MC; end
`endif
      default: lat = 0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [63:0] r;
    bit wr;
    int lat;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_run = 1'b0; cyc = 0;
    end else begin
      cyc++;
      if (m_run) begin
        if (cyc == m_done_at) begin
          if (m_pend_wr) {m_hi, m_lo} = m_pend;
          m_run = 1'b0;
        end
      end else begin
        model_op(MDOp, A, B, m_hi, m_lo, r, wr, lat);
        if (Start && lat != 0) begin
          m_pend = r; m_pend_wr = wr; m_run = 1'b1; m_done_at = cyc + lat;
        end else if (MDOp == MD_MTHI) m_hi = A;
        else if (MDOp == MD_MTLO) m_lo = A;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check32("model_busy", {31'd0, Busy}, {31'd0, m_run});
      check32("model_hi", HI, m_hi);
      check32("model_lo", LO, m_lo);
    end
  end

  // ---------------- drivers ----------------
  // Launch an op at the current negedge and count the Busy-high cycles.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MDOp = MD_NOP;
    n = 0;
    while (Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_move(input logic [3:0] op, input logic [31:0] v);
    MDOp = op; A = v;
    @(negedge clk);
    MDOp = MD_NOP;
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    do_op(op, a, b, n);
    check32({name, "_busy_cycles"}, n, exp_n);
    check32({name, "_hi"}, HI, exp_hi);
    check32({name, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    int n;
    #2;
    check32("reset_busy", {31'd0, Busy}, 32'd0);
    check32("reset_hi", HI, 32'd0);
    check32("reset_lo", LO, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("mult_neg", MD_MULT, 32'hFFFFFFFE, 32'd3, MC, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, MC, 32'h00000001, 32'hFFFFFFFE);
    run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, DC, 32'h00000000, 32'h80000000);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, DC, 32'd2, 32'd14);
    run_op("nop_start", MD_NOP, 32'd5, 32'd5, 0, 32'd2, 32'd14);

    do_move(MD_MTHI, 32'h1234);
    do_move(MD_MTLO, 32'h5678);
    check32("mthi", HI, 32'h1234);
    check32("mtlo", LO, 32'h5678);
    run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, DC, 32'h1234, 32'h5678);

    // mthi issued while running must be dropped
    Start = 1'b1; MDOp = MD_DIVU; A = 32'd5; B = 32'd0;
    @(negedge clk);
    Start = 1'b0; MDOp = MD_MTHI; A = 32'hDEAD;
    @(negedge clk);
    MDOp = MD_NOP;
    n = 0;
    while (Busy && n < 40) begin n++; @(negedge clk); end
    check32("mthi_in_run_busy", n, DC - 1);
    check32("mthi_in_run_hi", HI, 32'h1234);

    // asynchronous reset in cycle 4 of a divide
    Start = 1'b1; MDOp = MD_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0; MDOp = MD_NOP;
    repeat (3) @(negedge clk);
    check32("pre_reset_busy", {31'd0, Busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check32("async_busy", {31'd0, Busy}, 32'd0);
    check32("async_hi", HI, 32'd0);
    check32("async_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op("mult_after_rst", MD_MULT, 32'd6, 32'd7, MC, 32'd0, 32'd42);

    // accumulate ops
    do_move(MD_MTHI, 32'd0);
    do_move(MD_MTLO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", MD_MADDU, 32'd1, 32'd1, MC, 32'd1, 32'd0);
    run_op("msub", MD_MSUB, 32'd2, 32'd3, MC, 32'd0, 32'hFFFFFFFA);
`else
    run_op("maddu_off", MD_MADDU, 32'd1, 32'd1, 0, 32'd0, 32'hFFFFFFFF);
    run_op("msub_off", MD_MSUB, 32'd2, 32'd3, 0, 32'd0, 32'hFFFFFFFF);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
